// File: rtl/tetris_soc_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_soc_pio_pkg
// Purpose  : Shared constants for the SoC PIO family.
//            - Avalon-MM register word addresses.
//            - Edge-capture mode encodings.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_soc_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/tetris_soc_gpio_pio_if.sv
`default_nettype none
// ============================================================================
// Module   : tetris_soc_gpio_pio_if
// Purpose  : Avalon-MM slave bus bundle for the GPIO PIO.
// Signals  : address, chipselect, write_n, writedata (master -> slave)
//            readdata (slave -> master, zero-wait)
// Revision : 1.0 - initial release
// ============================================================================
interface tetris_soc_gpio_pio_if;
    import tetris_soc_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/tetris_soc_sync_bus.sv
`default_nettype none
// ============================================================================
// Module   : tetris_soc_sync_bus
// Purpose  : WIDTH-bit, STAGES-deep flop synchroniser for asynchronous inputs.
// Ports    : clk, reset_n (sync, active-low), d_i (async in), q_o (sync out)
// Revision : 1.0 - initial release
// ============================================================================
module tetris_soc_sync_bus #(
    parameter int WIDTH  = 14,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);
    import tetris_soc_pio_pkg::*;

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tetris_soc_gpio_pio.sv
`default_nettype none
// ============================================================================
// Module   : tetris_soc_gpio_pio
// Purpose  : Parametrised Avalon-MM GPIO slave: data/direction registers,
//            atomic set/clear aliases, synchronised input with edge capture
//            and a level interrupt.
// Ports    : clk, reset_n (sync, active-low)
//            bus      - Avalon-MM slave (address/chipselect/write_n/
//                       writedata/readdata)
//            in_port  - asynchronous external inputs
//            out_port - output data register
//            out_en   - per-bit output enable (direction)
//            irq      - level interrupt, active high
// Revision : 1.0 - initial release
// ============================================================================
module tetris_soc_gpio_pio
    import tetris_soc_pio_pkg::*;
#(
    parameter int                   DATA_WIDTH  = 14,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                   EDGE_TYPE   = 0,
    parameter int                   SYNC_STAGES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    tetris_soc_gpio_pio_if.slave       bus,
    input  wire logic [DATA_WIDTH-1:0] in_port,
    output logic      [DATA_WIDTH-1:0] out_port,
    output logic      [DATA_WIDTH-1:0] out_en,
    output logic                       irq
);

    localparam int            ARM_W   = 3;
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [DATA_WIDTH-1:0] dir_q,   dir_d;
    logic [DATA_WIDTH-1:0] mask_q,  mask_d;
    logic [DATA_WIDTH-1:0] cap_q,   cap_d;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [ARM_W-1:0]      arm_q,   arm_d;

    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  wr_en;

    tetris_soc_sync_bus #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (in_sync)
    );

    assign wr_en = bus.chipselect && !bus.write_n;
    assign wdata = bus.writedata[DATA_WIDTH-1:0];

    // Edge detection is held off until the arming counter saturates, so a
    // pin that is already high when reset releases does not look like a
    // fresh 0->1 transition while the synchroniser and in_prev fill.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_raw = in_sync & ~prev_q;
            EDGE_FALL: edge_raw = ~in_sync & prev_q;
            default:   edge_raw = in_sync ^ prev_q;
        endcase
        edge_det = (arm_q == ARM_MAX) ? edge_raw : '0;
    end

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        cap_d  = cap_q;
        arm_d  = (arm_q == ARM_MAX) ? arm_q : arm_q + 1'b1;

        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_d = wdata;
                ADDR_DIR:      dir_d  = wdata;
                ADDR_IRQ_MASK: mask_d = wdata;
                ADDR_EDGE_CAP: cap_d  = cap_q & ~wdata;
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLR:   data_d = data_q & ~wdata;
                default:       ;
            endcase
        end

        // OR-in after the clear so a same-cycle new edge survives the W1C.
        cap_d = cap_d | edge_det;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            dir_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            prev_q <= in_sync;
            arm_q  <= arm_d;
        end
    end

    always_comb begin
        case (bus.address)
            ADDR_DATA:     rd_val = (dir_q & data_q) | (~dir_q & in_sync);
            ADDR_DIR:      rd_val = dir_q;
            ADDR_IRQ_MASK: rd_val = mask_q;
            ADDR_EDGE_CAP: rd_val = cap_q;
            default:       rd_val = '0;
        endcase
        bus.readdata = 32'(rd_val);
    end

    assign out_port = data_q;
    assign out_en   = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: doc/tetris_soc_gpio_pio.md
Name: tetris_soc_gpio_pio

Overview:
Parametrised Avalon-MM GPIO slave. It is the successor to the fixed 14-bit output-only LED PIO used in the SoC.
- Configurable width.
- Per-bit direction register.
- Atomic set/clear output aliases.
- Synchronised input sampling with edge capture.
- Level interrupt to the Nios II IRQ controller.
Sits on the system interconnect beside the other PIOs and drives board LEDs/keys/switches.

Parameters:
DATA_WIDTH, 14, number of GPIO bits (1..32).
RESET_VALUE, 0, data_out value after reset (DATA_WIDTH bits).
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data; bits above DATA_WIDTH ignored
readdata  output  32  read data, zero-extended
in_port  input  DATA_WIDTH  asynchronous external inputs
out_port  output  DATA_WIDTH  output data register
out_en  output  DATA_WIDTH  per-bit output enable (= direction)
irq  output  1  level interrupt, active high

Behaviour:
- Interface timing: one clock domain (clk). Reset is synchronous, active-low: all state changes only on a clk rising edge with reset_n==0.
- Write: chipselect && !write_n at a clk edge. Reads are zero-wait: readdata is combinational from registers and address.
- Register map, reset values in brackets:
  - 0 DATA: read = (dir & data_out) | (~dir & in_sync); write loads data_out regardless of dir. [RESET_VALUE]
  - 1 DIR: read/write; 1 = output. [0]
  - 2 IRQ_MASK: read/write. [0]
  - 3 EDGE_CAP: read; write-1-to-clear per bit. [0]
  - 4 OUTSET: data_out |= writedata; reads 0.
  - 5 OUTCLR: data_out &= ~writedata; reads 0.
  - 6, 7: reserved; reads 0, writes ignored.
- Outputs: out_port = data_out, out_en = dir, irq = |(edge_cap & irq_mask). irq is combinational from flops, with no extra register stage.
- Input path:
  - in_port passes through SYNC_STAGES flops to give in_sync.
  - in_prev is in_sync delayed one cycle.
  - edge_det per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = XOR of the two.
- Latency: in_port changes before edge k. edge_cap and irq are visible after edge k+SYNC_STAGES. DATA readback of an input bit is visible after edge k+SYNC_STAGES-1.
- Arming counter:
  - Reset clears the counter; it counts to SYNC_STAGES+1 and saturates.
  - edge_det is gated off until saturated, so inputs held high through reset never produce a spurious capture.
- Collision: the same-cycle W1C of bit i and a new edge on bit i leaves the bit set (set wins).
- Capture is independent of mask and direction. An edge on an output-configured bit is still captured, because in_port is sampled externally.
- Reset asserted mid-operation:
  - Next edge restores all reset values, flushes synchroniser and in_prev to 0, and re-arms the counter.
  - irq deasserts in that same cycle.
- Write data width: writedata[31:DATA_WIDTH] is ignored. readdata[31:DATA_WIDTH] is always 0.

Decomposition:
- Shared package tetris_soc_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLR;
  - edge-mode localparams EDGE_RISE/EDGE_FALL/EDGE_ANY.
- One sub-module, tetris_soc_sync_bus: a DATA_WIDTH-wide, SYNC_STAGES-deep synchroniser with synchronous active-low reset. It is reused by future input-only PIOs.

Test Plan:
1. Reset with DATA_WIDTH=14, RESET_VALUE=14'h0155 -> out_port=0x0155, out_en=0, irq=0. Reads of addr 0..7 return 0x0155 only for DATA when dir=0x3FFF, otherwise 0.
2. Write DIR=0x3FFF, DATA=0x0F0F, OUTSET=0x3000, OUTCLR=0x000F -> out_port=0x3F00, and DATA reads 0x3F00.
3. EDGE_TYPE=0, IRQ_MASK=0x0004, in_port bit2 0->1 before edge k:
   - EDGE_CAP reads 0x0004 and irq=1 after edge k+2;
   - W1C 0x0004 -> irq=0 next cycle.
4. in_port=0x3FFF held through reset release -> EDGE_CAP stays 0 for 10 cycles and irq=0.
5. W1C of bit5 in the same cycle its rising edge is captured -> EDGE_CAP bit5 remains 1.
6. With irq=1 and data_out=0x1234, assert reset_n=0 for one edge -> irq=0, out_port=RESET_VALUE, EDGE_CAP=0, next edge also 0.
